karatsuba_mult_arbiter: RTL and testbench

- Shares one instance of the combinational karatsuba_mult_8 (8x8 unsigned multiply, 16-bit product) among NUM_REQ requesters.
- Uses round-robin arbitration, valid/ready handshakes on every requester and on the response, and a two-stage pipeline (operand register, then result register).
- Sits between the client blocks issuing multiply jobs and the shared multiplier datapath.
- Returns each product tagged with the index of the requester that issued it.

---
 rtl/karatsuba_mult_arbiter.sv | 135 +++++++++++++
 tb/tb_karatsuba_mult_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/karatsuba_mult_arbiter.sv
// Round-robin arbiter that shares one 8x8 Karatsuba multiplier among NUM_REQ requesters.
// Two-stage pipeline: operand register, then result register; each product is tagged with the requester index.

module karatsuba_mult_8 (
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    output logic [15:0] p
);
    logic [3:0]  xh, xl, yh, yl;
    logic [7:0]  z2, z0;
    logic [4:0]  xs, ys;
    logic [9:0]  zm;
    logic [15:0] z1;

    assign xh = x[7:4];
    assign xl = x[3:0];
    assign yh = y[7:4];
    assign yl = y[3:0];
    assign z2 = xh * yh;
    assign z0 = xl * yl;
    assign xs = {1'b0, xh} + {1'b0, xl};
    assign ys = {1'b0, yh} + {1'b0, yl};
    assign zm = xs * ys;
    // Middle term (xh*yl + xl*yh) recovered from the single cross product.
    assign z1 = 16'(zm) - 16'(z2) - 16'(z0);
    assign p  = {z2, 8'h00} + (z1 << 4) + 16'(z0);
endmodule

module karatsuba_mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_x,
    input  logic [8*NUM_REQ-1:0] req_y,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [15:0]          rsp_out,
    input  logic                 rsp_ready
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // a holder of valid data keeps it stable until that edge, and ready never depends on data.

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] gnt_id;
    logic [ID_W-1:0] scan_id;
    logic [NUM_REQ-1:0] gnt;
    logic            any_gnt;
    logic [7:0]      gnt_x, gnt_y;
    logic            op_valid;
    logic [7:0]      op_x, op_y;
    logic [ID_W-1:0] op_id;
    logic            adv_out, adv_op, accept;
    logic [15:0]     product;
    logic [7:0]      x_arr [NUM_REQ];
    logic [7:0]      y_arr [NUM_REQ];
    int              scan;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_split
        assign x_arr[i] = req_x[8*i +: 8];
        assign y_arr[i] = req_y[8*i +: 8];
    end

    assign adv_out = !rsp_valid || rsp_ready;
    assign adv_op  = !op_valid || adv_out;
    assign accept  = adv_op && any_gnt;

    // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        gnt     = '0;
        any_gnt = 1'b0;
        gnt_id  = '0;
        gnt_x   = '0;
        gnt_y   = '0;
        scan    = 0;
        scan_id = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = int'(ptr) + k;
            if (scan >= NUM_REQ) scan = scan - NUM_REQ;
            scan_id = ID_W'(scan);
            if (!any_gnt && req_valid[scan_id]) begin
                any_gnt      = 1'b1;
                gnt[scan_id] = 1'b1;
                gnt_id       = scan_id;
                gnt_x        = x_arr[scan_id];
                gnt_y        = y_arr[scan_id];
            end
        end
    end

    assign req_ready = (rst_n && adv_op) ? gnt : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid <= 1'b0;
            op_x     <= '0;
            op_y     <= '0;
            op_id    <= '0;
        end else if (adv_op) begin
            op_valid <= any_gnt;
            op_x     <= gnt_x;
            op_y     <= gnt_y;
            op_id    <= gnt_id;
        end
    end

    karatsuba_mult_8 u_mult (
        .x (op_x),
        .y (op_y),
        .p (product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_out   <= '0;
        end else if (adv_out) begin
            rsp_valid <= op_valid;
            rsp_id    <= op_id;
            rsp_out   <= product;
        end
    end
endmodule

// File: tb/tb_karatsuba_mult_arbiter.sv
// Bench for karatsuba_mult_arbiter: a reference arbiter/pipeline model checks grants every cycle,
// a scoreboard queue checks every response, and scenario tasks check the directed cases.

module tb_karatsuba_mult_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int W       = ID_W + 16;

    logic                 clk;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_x;
    logic [8*NUM_REQ-1:0] req_y;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 rsp_valid;
    logic [ID_W-1:0]      rsp_id;
    logic [15:0]          rsp_out;
    logic                 rsp_ready;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] exp_q[$];

    karatsuba_mult_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_out   (rsp_out),
        .rsp_ready (rsp_ready)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time %0t, limit 500000", $time);
        $fatal(1, "watchdog expired");
    end

    // reference model state
    int   m_ptr;
    logic m_op_v;
    logic m_rsp_v;

    function automatic int rr_pick(input int p, input logic [NUM_REQ-1:0] v);
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (p + k) % NUM_REQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Inputs change at posedge+1, so values at the negedge are the ones the next edge samples.
    always @(negedge clk) begin
        logic             m_adv_out, m_adv_op;
        logic [NUM_REQ-1:0] exp_gnt;
        logic [W-1:0]     exp_v;
        logic [15:0]      prod;
        int               g;
        if (!rst_n) begin
            m_ptr   = 0;
            m_op_v  = 1'b0;
            m_rsp_v = 1'b0;
            exp_q.delete();
        end else begin
            m_adv_out = !m_rsp_v || rsp_ready;
            m_adv_op  = !m_op_v || m_adv_out;
            g = m_adv_op ? rr_pick(m_ptr, req_valid) : -1;
            exp_gnt = '0;
            if (g >= 0) exp_gnt[g] = 1'b1;
            vectors++;
            if (req_ready !== exp_gnt) begin
                miscompares++;
                $display("FAIL grant @%0t: got %b want %b", $time, req_ready, exp_gnt);
            end
            vectors++;
            if (rsp_valid !== m_rsp_v) begin
                miscompares++;
                $display("FAIL rsp_valid @%0t: got %b want %b", $time, rsp_valid, m_rsp_v);
            end
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_rsp @%0t: got id %0d out %h want none", $time, rsp_id, rsp_out);
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({rsp_id, rsp_out} !== exp_v) begin
                        miscompares++;
                        $display("FAIL rsp_data @%0t: got id %0d out %h want id %0d out %h",
                                 $time, rsp_id, rsp_out, exp_v[W-1:16], exp_v[15:0]);
                    end
                end
            end
            if (m_adv_out) m_rsp_v = m_op_v;
            if (m_adv_op) begin
                m_op_v = (g >= 0);
                if (g >= 0) begin
                    prod = 16'(req_x[8*g +: 8]) * 16'(req_y[8*g +: 8]);
                    exp_q.push_back({ID_W'(g), prod});
                    m_ptr = (g + 1) % NUM_REQ;
                end
            end
        end
    end

    // driver tasks
    task automatic set_ops(input int i, input logic [7:0] x, input logic [7:0] y);
        req_x[8*i +: 8] = x;
        req_y[8*i +: 8] = y;
    endtask

    task automatic apply_reset();
        req_valid = '0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Each requester drops valid right after its accept edge.
    task automatic run_oneshot(input int budget);
        logic [NUM_REQ-1:0] acc;
        int n;
        n = 0;
        while (req_valid != '0 && n < budget) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1 req_valid = req_valid & ~acc;
            n++;
        end
        vectors++;
        if (req_valid !== '0) begin
            miscompares++;
            $display("FAIL oneshot_timeout: pending %b want 0000", req_valid);
            req_valid = '0;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d jobs outstanding want 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // scenarios
    task automatic test_reset();
        #2 req_valid = '1;
        #1;
        vectors++;
        if (req_ready !== '0) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        vectors++;
        if ({rsp_valid, rsp_id, rsp_out} !== '0) begin
            miscompares++;
            $display("FAIL reset_rsp: got v%b id %0d out %h want v0 id 0 out 0000", rsp_valid, rsp_id, rsp_out);
        end
        req_valid = '0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        set_ops(0, 8'h79, 8'h81);
        req_valid = 4'b0001;
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL single_grant: got %b want 0001", req_ready);
        end
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_early: got rsp_valid %b want 0", rsp_valid);
        end
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_out !== 16'h3CF9) begin
            miscompares++;
            $display("FAIL single_rsp: got v%b id %0d out %h want v1 id 0 out 3cf9", rsp_valid, rsp_id, rsp_out);
        end
        wait_drain(10);
    endtask

    task automatic test_all_four();
        logic [NUM_REQ-1:0] want;
        logic [15:0] exp_out [4];
        apply_reset();
        rsp_ready = 1'b1;
        set_ops(0, 8'h02, 8'h51);
        set_ops(1, 8'h30, 8'h0B);
        set_ops(2, 8'h08, 8'h02);
        set_ops(3, 8'hFF, 8'hFF);
        exp_out[0] = 16'h00A2;
        exp_out[1] = 16'h0210;
        exp_out[2] = 16'h0010;
        exp_out[3] = 16'hFE01;
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            want = 4'b0001 << (i % 4);
            vectors++;
            if (req_ready !== want) begin
                miscompares++;
                $display("FAIL all_four_grant%0d: got %b want %b", i, req_ready, want);
            end
            if (i >= 2) begin
                vectors++;
                if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(i - 2) || rsp_out !== exp_out[i-2]) begin
                    miscompares++;
                    $display("FAIL all_four_rsp%0d: got v%b id %0d out %h want v1 id %0d out %h",
                             i - 2, rsp_valid, rsp_id, rsp_out, i - 2, exp_out[i-2]);
                end
            end
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        wait_drain(10);
    endtask

    task automatic test_backpressure();
        logic [NUM_REQ-1:0] acc;
        int accepts;
        accepts = 0;
        rsp_ready = 1'b0;
        set_ops(1, 8'h30, 8'h0B);
        set_ops(2, 8'h11, 8'h22);
        req_valid = 4'b0110;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            accepts += $countones(acc);
            if (c >= 2) begin
                vectors++;
                if (req_ready !== '0 || rsp_valid !== 1'b1 || rsp_out !== 16'h0210) begin
                    miscompares++;
                    $display("FAIL bp_hold%0d: got ready %b v%b out %h want ready 0000 v1 out 0210",
                             c, req_ready, rsp_valid, rsp_out);
                end
            end
            @(posedge clk);
            #1 req_valid = req_valid & ~acc;
        end
        vectors++;
        if (accepts != 2) begin
            miscompares++;
            $display("FAIL bp_accepts: got %0d want 2", accepts);
        end
        rsp_ready = 1'b1;
        wait_drain(10);
    endtask

    task automatic test_rr_wrap();
        logic [NUM_REQ-1:0] seq [3];
        apply_reset();
        rsp_ready = 1'b1;
        set_ops(1, 8'h05, 8'h07);
        set_ops(2, 8'h09, 8'h0A);
        set_ops(3, 8'hC8, 8'h03);
        req_valid = 4'b0100;
        run_oneshot(5);
        seq[0] = 4'b1000;
        seq[1] = 4'b0010;
        seq[2] = 4'b1000;
        req_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (req_ready !== seq[i]) begin
                miscompares++;
                $display("FAIL rr_wrap%0d: got %b want %b", i, req_ready, seq[i]);
            end
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        wait_drain(10);
    endtask

    task automatic test_zero();
        bit seen;
        seen = 1'b0;
        rsp_ready = 1'b1;
        set_ops(2, 8'h00, 8'h00);
        req_valid = 4'b0100;
        run_oneshot(5);
        for (int n = 0; n < 6 && !seen; n++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                seen = 1'b1;
                vectors++;
                if (rsp_out !== 16'h0000 || rsp_id !== 2'd2) begin
                    miscompares++;
                    $display("FAIL zero_rsp: got id %0d out %h want id 2 out 0000", rsp_id, rsp_out);
                end
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL zero_timeout: got no rsp_valid want rsp_valid 1");
        end
        wait_drain(10);
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 80; c++) begin
            req_valid = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
            for (int i = 0; i < NUM_REQ; i++)
                set_ops(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_drain(20);
    endtask

    task automatic test_reset_midflight();
        logic [NUM_REQ-1:0] acc;
        rsp_ready = 1'b0;
        set_ops(0, 8'h12, 8'h34);
        set_ops(1, 8'h56, 8'h78);
        req_valid = 4'b0011;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1 req_valid = req_valid & ~acc;
        end
        vectors++;
        if (rsp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pre: got rsp_valid %b want 1", rsp_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_out !== 16'h0000 || rsp_id !== 2'd0) begin
            miscompares++;
            $display("FAIL mid_reset: got v%b id %0d out %h want v0 id 0 out 0000", rsp_valid, rsp_id, rsp_out);
        end
        req_valid = '0;
        set_ops(2, 8'h0F, 8'h0F);
        set_ops(3, 8'h80, 8'h02);
        rsp_ready = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 req_valid = 4'b1100;
        @(negedge clk);
        acc = req_valid & req_ready;
        vectors++;
        if (req_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL mid_first_grant: got %b want 0100", req_ready);
        end
        @(posedge clk);
        #1 req_valid = req_valid & ~acc;
        run_oneshot(5);
        wait_drain(10);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_all_four();
        test_backpressure();
        test_rr_wrap();
        test_zero();
        test_back_to_back();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
